parking_ctrl: RTL and testbench

PARKING_CTRL -- requirements
Module: parking_ctrl

---
 rtl/parking_ctrl.sv | 155 +++++++++++++++
 tb/tb_parking_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl.sv
// Parking controller: tracks university and public occupancy against a shared
// pool of physical spaces, with a public cap that changes by time-of-day band.
// Entry/exit results are registered one-cycle ack/rej pulses.
module parking_ctrl #(
  parameter int TOTAL_SPACES   = 700,
  parameter int UNI_MAX        = 500,
  parameter int PUB_BASE       = 200,
  parameter int PUB_MID        = 250,
  parameter int PUB_LATE       = 350,
  parameter int MID_HOUR       = 13,
  parameter int LATE_HOUR      = 16,
  parameter int START_HOUR     = 8,
  parameter int TICKS_PER_HOUR = 3600,
  parameter int CW             = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          entry_req,
  input  logic          entry_uni,
  input  logic          exit_req,
  input  logic          exit_uni,
  output logic          entry_ack,
  output logic          entry_rej,
  output logic          exit_ack,
  output logic          exit_rej,
  output logic [CW-1:0] uni_parked,
  output logic [CW-1:0] pub_parked,
  output logic [CW-1:0] uni_free,
  output logic [CW-1:0] pub_free,
  output logic          uni_avail,
  output logic          pub_avail,
  output logic [4:0]    hour
);

  // Two extra bits so cap - parked and the shared-pool difference can go
  // negative without wrapping before they are clamped.
  localparam int SW = CW + 2;
  localparam int TW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_HOUR - 1);
  localparam logic [4:0]    START_H   = 5'(START_HOUR);
  localparam logic [4:0]    MID_H     = 5'(MID_HOUR);
  localparam logic [4:0]    LATE_H    = 5'(LATE_HOUR);
  localparam logic [CW-1:0] ONE       = CW'(1);

  localparam logic signed [SW-1:0] TOTAL_S    = SW'(TOTAL_SPACES);
  localparam logic signed [SW-1:0] UNI_MAX_S  = SW'(UNI_MAX);
  localparam logic signed [SW-1:0] PUB_BASE_S = SW'(PUB_BASE);
  localparam logic signed [SW-1:0] PUB_MID_S  = SW'(PUB_MID);
  localparam logic signed [SW-1:0] PUB_LATE_S = SW'(PUB_LATE);

  // Grantable spaces for a class: headroom under its cap, clamped at zero,
  // further limited by what is physically left in the shared pool.
  function automatic logic [CW-1:0] free_calc(
    input logic signed [SW-1:0] room,
    input logic signed [SW-1:0] shared
  );
    logic signed [SW-1:0] r;
    logic signed [SW-1:0] s;
    r = (room < 0) ? '0 : room;
    s = (shared < 0) ? '0 : shared;
    if (s < r) r = s;
    return CW'(r);
  endfunction

  logic [TW-1:0] tick_q, tick_d;
  logic [4:0]    hour_q, hour_d;
  logic [CW-1:0] uni_parked_q, uni_parked_d;
  logic [CW-1:0] pub_parked_q, pub_parked_d;
  logic          entry_ack_q, entry_ack_d;
  logic          entry_rej_q, entry_rej_d;
  logic          exit_ack_q, exit_ack_d;
  logic          exit_rej_q, exit_rej_d;

  logic signed [SW-1:0] pub_cap_s;
  logic signed [SW-1:0] shared_s;
  logic [CW-1:0]        uni_free_c, pub_free_c;
  logic                 entry_grant, exit_grant;

  // Band selection and per-class free space from the registered state.
  always_comb begin
    pub_cap_s = PUB_BASE_S;
    if (hour_q >= LATE_H) begin
      pub_cap_s = PUB_LATE_S;
    end else if (hour_q >= MID_H) begin
      pub_cap_s = PUB_MID_S;
    end
    shared_s   = TOTAL_S - $signed({2'b00, uni_parked_q}) - $signed({2'b00, pub_parked_q});
    uni_free_c = free_calc(UNI_MAX_S - $signed({2'b00, uni_parked_q}), shared_s);
    pub_free_c = free_calc(pub_cap_s - $signed({2'b00, pub_parked_q}), shared_s);
  end

  // Next-state: grant decisions against pre-edge state, count update, time of day.
  always_comb begin
    tick_d       = tick_q + TW'(1);
    hour_d       = hour_q;
    uni_parked_d = uni_parked_q;
    pub_parked_d = pub_parked_q;

    entry_grant = entry_req && (entry_uni ? (uni_free_c != '0) : (pub_free_c != '0));
    exit_grant  = exit_req && (exit_uni ? (uni_parked_q != '0) : (pub_parked_q != '0));

    entry_ack_d = entry_grant;
    entry_rej_d = entry_req && !entry_grant;
    exit_ack_d  = exit_grant;
    exit_rej_d  = exit_req && !exit_grant;

    // Entry and exit are independent; same-class grants cancel to a net zero.
    if (entry_grant && entry_uni)  uni_parked_d = uni_parked_d + ONE;
    if (entry_grant && !entry_uni) pub_parked_d = pub_parked_d + ONE;
    if (exit_grant && exit_uni)    uni_parked_d = uni_parked_d - ONE;
    if (exit_grant && !exit_uni)   pub_parked_d = pub_parked_d - ONE;

    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end
  end

  // State register; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      hour_q       <= START_H;
      uni_parked_q <= '0;
      pub_parked_q <= '0;
      entry_ack_q  <= 1'b0;
      entry_rej_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_rej_q   <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      hour_q       <= hour_d;
      uni_parked_q <= uni_parked_d;
      pub_parked_q <= pub_parked_d;
      entry_ack_q  <= entry_ack_d;
      entry_rej_q  <= entry_rej_d;
      exit_ack_q   <= exit_ack_d;
      exit_rej_q   <= exit_rej_d;
    end
  end

  assign entry_ack  = entry_ack_q;
  assign entry_rej  = entry_rej_q;
  assign exit_ack   = exit_ack_q;
  assign exit_rej   = exit_rej_q;
  assign uni_parked = uni_parked_q;
  assign pub_parked = pub_parked_q;
  assign uni_free   = uni_free_c;
  assign pub_free   = pub_free_c;
  assign uni_avail  = (uni_free_c != '0);
  assign pub_avail  = (pub_free_c != '0);
  assign hour       = hour_q;

endmodule

// File: tb/tb_parking_ctrl.sv
// Bench for parking_ctrl with a small verification configuration and a
// behavioural occupancy/time model.
module tb_parking_ctrl;

  localparam int TPH   = 4;
  localparam int TOTAL = 6;
  localparam int UMAX  = 4;
  localparam int PBASE = 2;
  localparam int PMID  = 3;
  localparam int PLATE = 5;
  localparam int MIDH  = 9;
  localparam int LATEH = 10;
  localparam int STH   = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          entry_req, entry_uni, exit_req, exit_uni;
  logic          entry_ack, entry_rej, exit_ack, exit_rej;
  logic [CW-1:0] uni_parked, pub_parked, uni_free, pub_free;
  logic          uni_avail, pub_avail;
  logic [4:0]    hour;

  always #5 clk = ~clk;

  parking_ctrl #(
    .TOTAL_SPACES(TOTAL), .UNI_MAX(UMAX), .PUB_BASE(PBASE), .PUB_MID(PMID),
    .PUB_LATE(PLATE), .MID_HOUR(MIDH), .LATE_HOUR(LATEH), .START_HOUR(STH),
    .TICKS_PER_HOUR(TPH), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req), .entry_uni(entry_uni),
    .exit_req(exit_req), .exit_uni(exit_uni),
    .entry_ack(entry_ack), .entry_rej(entry_rej),
    .exit_ack(exit_ack), .exit_rej(exit_rej),
    .uni_parked(uni_parked), .pub_parked(pub_parked),
    .uni_free(uni_free), .pub_free(pub_free),
    .uni_avail(uni_avail), .pub_avail(pub_avail),
    .hour(hour)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_hour, m_tick, m_uni, m_pub;
  bit m_eack, m_erej, m_xack, m_xrej;

  function automatic int pub_cap(input int h);
    if (h >= LATEH) return PLATE;
    if (h >= MIDH) return PMID;
    return PBASE;
  endfunction

  function automatic int m_free(input bit u);
    int room, sh;
    room = u ? (UMAX - m_uni) : (pub_cap(m_hour) - m_pub);
    sh   = TOTAL - m_uni - m_pub;
    if (room < 0) room = 0;
    if (sh < 0) sh = 0;
    return (sh < room) ? sh : room;
  endfunction

  task automatic model_reset();
    m_hour = STH; m_tick = 0; m_uni = 0; m_pub = 0;
    m_eack = 0; m_erej = 0; m_xack = 0; m_xrej = 0;
  endtask

  // One clock with the given requests; model advances from pre-edge state.
  task automatic cycle(input bit en, input bit eu, input bit ex, input bit xu);
    int  fe;
    bit  eg, xg;
    entry_req = en; entry_uni = eu; exit_req = ex; exit_uni = xu;
    @(posedge clk);
    fe = m_free(eu);
    eg = en && (fe > 0);
    xg = ex && (xu ? (m_uni > 0) : (m_pub > 0));
    m_eack = eg; m_erej = en && !eg;
    m_xack = xg; m_xrej = ex && !xg;
    if (eg) begin if (eu) m_uni++; else m_pub++; end
    if (xg) begin if (xu) m_uni--; else m_pub--; end
    m_tick++;
    if (m_tick == TPH) begin
      m_tick = 0;
      m_hour = (m_hour + 1) % 24;
    end
    #1;
    entry_req = 0; entry_uni = 0; exit_req = 0; exit_uni = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    entry_req = 1'b1; entry_uni = 1'b0; exit_req = 1'b1; exit_uni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    entry_req = 0; exit_req = 0; exit_uni = 0;
    checks++;
    if (hour !== 5'(STH) || uni_parked !== 4'd0 || pub_parked !== 4'd0) begin
      failures++;
      $display("FAIL reset_state hour=%0d uni=%0d pub=%0d expected hour=%0d uni=0 pub=0",
               hour, uni_parked, pub_parked, STH);
    end
    checks++;
    if ({entry_ack, entry_rej, exit_ack, exit_rej} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses got=%b expected=0000", {entry_ack, entry_rej, exit_ack, exit_rej});
    end
    checks++;
    if (uni_free !== 4'd4 || pub_free !== 4'd2 || uni_avail !== 1'b1 || pub_avail !== 1'b1) begin
      failures++;
      $display("FAIL reset_free uni_free=%0d pub_free=%0d avail=%b%b expected 4 2 11",
               uni_free, pub_free, uni_avail, pub_avail);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_pub_fill();
    bit exp_ack [3];
    exp_ack[0] = 1; exp_ack[1] = 1; exp_ack[2] = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (entry_ack !== exp_ack[i] || entry_rej !== !exp_ack[i]) begin
        failures++;
        $display("FAIL pub_fill_%0d ack=%b rej=%b expected ack=%b rej=%b",
                 i, entry_ack, entry_rej, exp_ack[i], !exp_ack[i]);
      end
    end
    checks++;
    if (pub_parked !== 4'd2 || pub_free !== 4'd0 || pub_avail !== 1'b0) begin
      failures++;
      $display("FAIL pub_fill_state parked=%0d free=%0d avail=%b expected 2 0 0",
               pub_parked, pub_free, pub_avail);
    end
  endtask

  task automatic test_band_mid();
    int n = 0;
    while (m_hour != MIDH && n < 20) begin cycle(0, 0, 0, 0); n++; end
    checks++;
    if (hour !== 5'(MIDH) || pub_free !== 4'd1) begin
      failures++;
      $display("FAIL band_mid hour=%0d pub_free=%0d expected hour=%0d pub_free=1", hour, pub_free, MIDH);
    end
    cycle(1, 0, 0, 0);
    checks++;
    if (entry_ack !== 1'b1 || entry_rej !== 1'b0 || pub_parked !== 4'd3) begin
      failures++;
      $display("FAIL band_mid_entry ack=%b rej=%b pub=%0d expected 1 0 3", entry_ack, entry_rej, pub_parked);
    end
  endtask

  task automatic test_band_late();
    int n = 0;
    while (m_hour != LATEH && n < 20) begin cycle(0, 0, 0, 0); n++; end
    checks++;
    if (hour !== 5'(LATEH) || pub_free !== 4'd2) begin
      failures++;
      $display("FAIL band_late hour=%0d pub_free=%0d expected hour=%0d pub_free=2", hour, pub_free, LATEH);
    end
    // Drop to two public cars so four university cars exactly fill the lot.
    cycle(0, 0, 1, 0);
    checks++;
    if (exit_ack !== 1'b1 || pub_parked !== 4'd2) begin
      failures++;
      $display("FAIL late_pub_exit ack=%b pub=%0d expected 1 2", exit_ack, pub_parked);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0);
      checks++;
      if (entry_ack !== 1'b1 || entry_rej !== 1'b0) begin
        failures++;
        $display("FAIL late_uni_entry_%0d ack=%b rej=%b expected 1 0", i, entry_ack, entry_rej);
      end
    end
    checks++;
    if (uni_parked !== 4'd4 || pub_free !== 4'd0 || uni_free !== 4'd0 || pub_avail !== 1'b0) begin
      failures++;
      $display("FAIL late_full uni=%0d pub_free=%0d uni_free=%0d pub_avail=%b expected 4 0 0 0",
               uni_parked, pub_free, uni_free, pub_avail);
    end
    cycle(1, 0, 0, 0);
    checks++;
    if (entry_ack !== 1'b0 || entry_rej !== 1'b1 || pub_parked !== 4'd2) begin
      failures++;
      $display("FAIL late_pub_rej ack=%b rej=%b pub=%0d expected 0 1 2", entry_ack, entry_rej, pub_parked);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    cycle(0, 0, 1, 1);
    cycle(1, 0, 0, 0);
    checks++;
    if (entry_ack !== 1'b1 || pub_parked !== 4'd3 || uni_parked !== 4'd3) begin
      failures++;
      $display("FAIL wrap_setup ack=%b pub=%0d uni=%0d expected 1 3 3", entry_ack, pub_parked, uni_parked);
    end
    while (m_hour != 0 && n < 200) begin cycle(0, 0, 0, 0); n++; end
    checks++;
    if (m_hour != 0 || hour !== 5'd0 || pub_free !== 4'd0 || pub_avail !== 1'b0 || pub_parked !== 4'd3) begin
      failures++;
      $display("FAIL wrap_hour hour=%0d pub_free=%0d pub=%0d waited=%0d expected hour=0 free=0 pub=3",
               hour, pub_free, pub_parked, n);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 0);
      checks++;
      if (exit_ack !== 1'b1 || exit_rej !== 1'b0) begin
        failures++;
        $display("FAIL wrap_exit_%0d ack=%b rej=%b expected 1 0", i, exit_ack, exit_rej);
      end
    end
    checks++;
    if (pub_parked !== 4'd1 || pub_free !== 4'd1) begin
      failures++;
      $display("FAIL wrap_after pub=%0d pub_free=%0d expected 1 1", pub_parked, pub_free);
    end
  endtask

  task automatic test_exit_edge();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    checks++;
    if (exit_rej !== 1'b1 || exit_ack !== 1'b0 || uni_parked !== 4'd0) begin
      failures++;
      $display("FAIL empty_exit ack=%b rej=%b uni=%0d expected 0 1 0", exit_ack, exit_rej, uni_parked);
    end
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    checks++;
    if (uni_parked !== 4'd4 || uni_free !== 4'd0 || uni_avail !== 1'b0) begin
      failures++;
      $display("FAIL uni_full uni=%0d free=%0d avail=%b expected 4 0 0", uni_parked, uni_free, uni_avail);
    end
    cycle(1, 1, 1, 1);
    checks++;
    if ({entry_ack, entry_rej, exit_ack, exit_rej} !== 4'b0110 || uni_parked !== 4'd3) begin
      failures++;
      $display("FAIL same_cycle_full pulses=%b uni=%0d expected 0110 3",
               {entry_ack, entry_rej, exit_ack, exit_rej}, uni_parked);
    end
    // With room available both same-class grants apply and cancel.
    cycle(1, 1, 1, 1);
    checks++;
    if ({entry_ack, entry_rej, exit_ack, exit_rej} !== 4'b1010 || uni_parked !== 4'd3) begin
      failures++;
      $display("FAIL same_cycle_net pulses=%b uni=%0d expected 1010 3",
               {entry_ack, entry_rej, exit_ack, exit_rej}, uni_parked);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uni_parked !== 4'd0 || pub_parked !== 4'd0 || hour !== 5'(STH) ||
        {entry_ack, entry_rej, exit_ack, exit_rej} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset uni=%0d pub=%0d hour=%0d pulses=%b expected 0 0 %0d 0000",
               uni_parked, pub_parked, hour, {entry_ack, entry_rej, exit_ack, exit_rej}, STH);
    end
    entry_req = 1'b1; entry_uni = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (uni_parked !== 4'd0 || entry_ack !== 1'b0 || hour !== 5'(STH)) begin
      failures++;
      $display("FAIL reset_ignores_req uni=%0d ack=%b hour=%0d expected 0 0 %0d",
               uni_parked, entry_ack, hour, STH);
    end
    entry_req = 1'b0; entry_uni = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit en, eu, ex, xu;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(99) < 60);
      eu = $urandom_range(1);
      ex = ($urandom_range(99) < 40);
      xu = $urandom_range(1);
      cycle(en, eu, ex, xu);
      checks++;
      if (entry_ack !== m_eack || entry_rej !== m_erej || exit_ack !== m_xack || exit_rej !== m_xrej ||
          uni_parked !== 4'(m_uni) || pub_parked !== 4'(m_pub) ||
          uni_free !== 4'(m_free(1)) || pub_free !== 4'(m_free(0)) ||
          uni_avail !== (m_free(1) > 0) || pub_avail !== (m_free(0) > 0) || hour !== 5'(m_hour)) begin
        failures++;
        $display("FAIL random_%0d got pulses=%b uni=%0d pub=%0d ufree=%0d pfree=%0d hour=%0d required pulses=%b uni=%0d pub=%0d ufree=%0d pfree=%0d hour=%0d",
                 i, {entry_ack, entry_rej, exit_ack, exit_rej}, uni_parked, pub_parked, uni_free, pub_free, hour,
                 {m_eack, m_erej, m_xack, m_xrej}, m_uni, m_pub, m_free(1), m_free(0), m_hour);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_req = 0; entry_uni = 0; exit_req = 0; exit_uni = 0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_pub_fill();
    test_band_mid();
    test_band_late();
    test_wrap();
    test_exit_edge();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
